// File: rtl/ysyx_23060236_axi_sram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ysyx_23060236_axi_sram : single-outstanding AXI4 responder over a word SRAM
// Revision: 1.0
// ============================================================================
module ysyx_23060236_axi_sram #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,

    output logic        io_slave_awready,
    input  logic        io_slave_awvalid,
    input  logic [31:0] io_slave_awaddr,
    input  logic [3:0]  io_slave_awid,
    input  logic [7:0]  io_slave_awlen,
    input  logic [2:0]  io_slave_awsize,
    input  logic [1:0]  io_slave_awburst,

    output logic        io_slave_wready,
    input  logic        io_slave_wvalid,
    input  logic [31:0] io_slave_wdata,
    input  logic [3:0]  io_slave_wstrb,
    input  logic        io_slave_wlast,

    input  logic        io_slave_bready,
    output logic        io_slave_bvalid,
    output logic [1:0]  io_slave_bresp,
    output logic [3:0]  io_slave_bid,

    output logic        io_slave_arready,
    input  logic        io_slave_arvalid,
    input  logic [31:0] io_slave_araddr,
    input  logic [3:0]  io_slave_arid,
    input  logic [7:0]  io_slave_arlen,
    input  logic [2:0]  io_slave_arsize,
    input  logic [1:0]  io_slave_arburst,

    input  logic        io_slave_rready,
    output logic        io_slave_rvalid,
    output logic [1:0]  io_slave_rresp,
    output logic [31:0] io_slave_rdata,
    output logic        io_slave_rlast,
    output logic [3:0]  io_slave_rid
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        R_WAIT = 3'd1,
        R_DATA = 3'd2,
        W_DATA = 3'd3,
        W_RESP = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] idx_step;
    logic [ADDR_WIDTH-1:0] aw_idx;
    logic [ADDR_WIDTH-1:0] ar_idx;
    logic [7:0]            len;
    logic [3:0]            id;
    logic                  incr;
    logic [8:0]            beat;
    logic [CW-1:0]         lat_cnt;
    logic [31:0]           rdata_q;
    logic [1:0]            bresp_q;
    logic [31:0]           mem [DEPTH];

    logic aw_hs, ar_hs, w_hs, r_hs, r_last, mem_we;
    logic unused;

    assign unused = ^{io_slave_awsize, io_slave_arsize,
                      io_slave_awaddr[31:ADDR_WIDTH+2], io_slave_awaddr[1:0],
                      io_slave_araddr[31:ADDR_WIDTH+2], io_slave_araddr[1:0]};

    assign aw_idx   = io_slave_awaddr[ADDR_WIDTH+1:2];
    assign ar_idx   = io_slave_araddr[ADDR_WIDTH+1:2];
    assign idx_step = incr ? idx + ADDR_WIDTH'(1) : idx;

    assign io_slave_awready = (state == IDLE);
    assign io_slave_arready = (state == IDLE) & ~io_slave_awvalid;
    assign io_slave_wready  = (state == W_DATA);
    assign io_slave_bvalid  = (state == W_RESP);
    assign io_slave_rvalid  = (state == R_DATA);
    assign io_slave_rlast   = r_last;
    assign io_slave_rdata   = rdata_q;
    assign io_slave_rresp   = 2'b00;
    assign io_slave_rid     = id;
    assign io_slave_bid     = id;
    assign io_slave_bresp   = bresp_q;

    assign aw_hs  = io_slave_awvalid & io_slave_awready;
    assign ar_hs  = io_slave_arvalid & io_slave_arready;
    assign w_hs   = io_slave_wvalid & io_slave_wready;
    assign r_hs   = io_slave_rvalid & io_slave_rready;
    assign r_last = (state == R_DATA) && (beat == {1'b0, len});
    // Beats past the announced length are dropped, never written.
    assign mem_we = w_hs && (beat <= {1'b0, len});

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (aw_hs)      state_nxt = W_DATA;
                else if (ar_hs) state_nxt = (LATENCY == 1) ? R_DATA : R_WAIT;
            end
            R_WAIT: if (lat_cnt == CW'(1))           state_nxt = R_DATA;
            R_DATA: if (r_hs && r_last)              state_nxt = IDLE;
            W_DATA: if (w_hs && io_slave_wlast)      state_nxt = W_RESP;
            W_RESP: if (io_slave_bready)             state_nxt = IDLE;
            default:                                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            len     <= '0;
            id      <= '0;
            incr    <= 1'b0;
            beat    <= '0;
            lat_cnt <= '0;
            rdata_q <= '0;
            bresp_q <= 2'b00;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        idx  <= aw_idx;
                        len  <= io_slave_awlen;
                        id   <= io_slave_awid;
                        incr <= |io_slave_awburst;
                        beat <= '0;
                    end else if (ar_hs) begin
                        idx     <= ar_idx;
                        len     <= io_slave_arlen;
                        id      <= io_slave_arid;
                        incr    <= |io_slave_arburst;
                        beat    <= '0;
                        lat_cnt <= CW'(LATENCY - 1);
                        if (LATENCY == 1) rdata_q <= mem[ar_idx];
                    end
                end
                R_WAIT: begin
                    lat_cnt <= lat_cnt - CW'(1);
                    // Fetch one cycle early so the word is present as rvalid rises.
                    if (lat_cnt == CW'(1)) rdata_q <= mem[idx];
                end
                R_DATA: begin
                    if (r_hs && !r_last) begin
                        beat    <= beat + 9'd1;
                        idx     <= idx_step;
                        rdata_q <= mem[idx_step];
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (beat != 9'h1FF) beat <= beat + 9'd1;
                        idx <= idx_step;
                        if (io_slave_wlast)
                            bresp_q <= (beat == {1'b0, len}) ? 2'b00 : 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (io_slave_wstrb[b]) mem[idx][8*b +: 8] <= io_slave_wdata[8*b +: 8];
            end
        end
    end

endmodule
`default_nettype wire
